// File: rtl/axis_upsizer_pkg.sv
// Shared elaboration-time helpers for the AXI-Stream upsizer: ratio legality
// check and lane-index width.
package axis_upsizer_pkg;

  // Legal when the input is whole bytes and the output holds a power-of-two
  // number of input beats.
  function automatic bit ratio_ok(input int s_width, input int m_width);
    int r;
    if (s_width <= 0 || (s_width % 8) != 0 || (m_width % s_width) != 0) return 1'b0;
    r = m_width / s_width;
    return (r >= 1) && ((r & (r - 1)) == 0);
  endfunction

  // Lane index width; a ratio of 1 uses a single index bit tied to zero.
  function automatic int idx_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs R narrow beats into one wide beat and
// flushes a zero-padded partial word when s_last lands mid-word.
module axis_upsizer
  import axis_upsizer_pkg::*;
#(
  parameter int S_BUS_WIDTH = 8,
  parameter int M_BUS_WIDTH = 32,
  localparam int S_BYTES = S_BUS_WIDTH / 8,
  localparam int R = M_BUS_WIDTH / S_BUS_WIDTH
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [S_BYTES-1:0][7:0]     s_data,
  input  logic [S_BYTES-1:0]          s_keep,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [R*S_BYTES-1:0][7:0]   m_data,
  output logic [R*S_BYTES-1:0]        m_keep,
  output logic                        m_last
);

  localparam int IW    = idx_width(R);
  localparam int ACC_N = (R > 1) ? R - 1 : 1;

  if (!ratio_ok(S_BUS_WIDTH, M_BUS_WIDTH)) begin : g_bad_ratio
    $error("axis_upsizer: M_BUS_WIDTH/S_BUS_WIDTH must be a power-of-two integer of byte-wide beats");
  end

  logic [IW-1:0]                     idx;
  logic                              idx_top;
  logic                              s_fire;
  logic                              complete;
  logic [ACC_N-1:0][S_BYTES-1:0][7:0] acc_data;
  logic [ACC_N-1:0][S_BYTES-1:0]      acc_keep;
  logic [R-1:0][S_BYTES-1:0][7:0]     next_data;
  logic [R-1:0][S_BYTES-1:0]          next_keep;

  // Handshake: s_valid && s_ready at posedge accepts a beat; m_valid && m_ready
  // at posedge retires the output word. s_ready never looks at s_valid/s_data/s_last.
  assign s_ready  = !m_valid || m_ready;
  assign s_fire   = s_valid && s_ready;
  assign complete = s_fire && (idx_top || s_last);

  if (R > 1) begin : g_idx
    always_ff @(posedge aclk) begin
      if (areset) begin
        idx <= '0;
      end else if (s_fire) begin
        idx <= complete ? '0 : idx + 1'b1;
      end
    end
    assign idx_top = (idx == IW'(R - 1));

    // Only lanes below the final one are buffered; the final beat goes
    // straight into the output register.
    always_ff @(posedge aclk) begin
      if (areset) begin
        acc_data <= '0;
        acc_keep <= '0;
      end else if (s_fire) begin
        if (complete) begin
          acc_keep <= '0;
        end else begin
          acc_data[idx] <= s_data;
          acc_keep[idx] <= s_keep;
        end
      end
    end
  end else begin : g_no_idx
    assign idx      = '0;
    assign idx_top  = 1'b1;
    assign acc_data = '0;
    assign acc_keep = '0;
  end

  // Next output word: buffered lanes below idx, the incoming beat at idx,
  // zeros above it.
  always_comb begin
    next_data = '0;
    next_keep = '0;
    for (int l = 0; l < R - 1; l++) begin
      if (l < int'(idx)) begin
        next_data[l] = acc_data[l];
        next_keep[l] = acc_keep[l];
      end
    end
    next_data[idx] = s_data;
    next_keep[idx] = s_keep;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
    end else if (complete) begin
      m_valid <= 1'b1;
      m_last  <= s_last;
      m_data  <= next_data;
      m_keep  <= next_keep;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
